// File: rtl/hcsr04_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : hcsr04_pkg                                                   |
// | Description : Shared types and constants for the HC-SR04 responder:        |
// |               FSM state encoding, default timing constants and the         |
// |               jitter LFSR seed/tap mask.                                   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package hcsr04_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    TRIG_HI = 3'd1,
    BURST   = 3'd2,
    ECHO    = 3'd3,
    HOLDOFF = 3'd4
  } state_e;

  localparam int TIMEOUT_US_DEF  = 38000;
  localparam int TRIG_MIN_US_DEF = 10;

  // Fibonacci LFSR, taps 16,14,13,11 -> bits 15,13,12,10.
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

endpackage
`default_nettype wire

// File: rtl/hcsr04_responder_us_tick_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : us_tick_gen                                                  |
// | Description : Microsecond prescaler. Counts 0..CLK_MHZ-1 and flags the     |
// |               last count. i_restart forces the count back to 0 so that a   |
// |               freshly entered state sees a full microsecond first.         |
// | Ports       : i_clk, i_rst (sync, active high), i_restart, o_tick          |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module us_tick_gen #(
  parameter int CLK_MHZ = 64
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_restart,
  output logic o_tick
);

  localparam int CW = (CLK_MHZ > 1) ? $clog2(CLK_MHZ) : 1;
  localparam logic [CW-1:0] C_LAST = CW'(CLK_MHZ - 1);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_restart) begin
      cnt_q <= '0;
    end else if (cnt_q == C_LAST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  assign o_tick = (cnt_q == C_LAST);

endmodule
`default_nettype wire

// File: rtl/hcsr04_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : hcsr04_responder                                             |
// | Description : Sensor-side HC-SR04 emulation. Accepts a trigger pulse of at |
// |               least TRIG_MIN_US and answers, BURST_US after the trigger    |
// |               fall, with an echo pulse of the programmed width in us,      |
// |               followed by a HOLDOFF_US dead time.                          |
// | Ports       : i_clk, i_rst     clock / sync active-high reset              |
// |               i_enable         allow new triggers (checked in IDLE)        |
// |               i_echo_us[15:0]  echo width in us, latched on accept         |
// |               i_trigger        asynchronous trigger pin                    |
// |               o_echo           echo pin (registered)                       |
// |               o_busy           state is not IDLE                           |
// |               o_short_trig     1-cycle pulse on a too-short trigger        |
// |               o_trig_count     accepted triggers, wraps                    |
// | Options     : HCSR04_RESP_JITTER_EN adds 0..7 us of LFSR jitter to the     |
// |               latched echo width (saturated to TIMEOUT_US).                |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module hcsr04_responder
  import hcsr04_pkg::*;
#(
  parameter int CLK_MHZ     = 64,
  parameter int TRIG_MIN_US = TRIG_MIN_US_DEF,
  parameter int BURST_US    = 200,
  parameter int TIMEOUT_US  = TIMEOUT_US_DEF,
  parameter int HOLDOFF_US  = 10000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_enable,
  input  logic [15:0] i_echo_us,
  input  logic        i_trigger,
  output logic        o_echo,
  output logic        o_busy,
  output logic        o_short_trig,
  output logic [15:0] o_trig_count
);

  localparam int MIN_CYC = TRIG_MIN_US * CLK_MHZ;
  localparam int CYC_W   = $clog2(MIN_CYC + 1);
  localparam logic [CYC_W-1:0] C_MIN_CYC   = CYC_W'(MIN_CYC);
  localparam logic [15:0]      C_BURST_LST = 16'(BURST_US - 1);
  localparam logic [15:0]      C_HOLD_LST  = 16'(HOLDOFF_US - 1);
  localparam logic [15:0]      C_TIMEOUT   = 16'(TIMEOUT_US);

  // Synchronizer and edge detect
  logic       sync1_q, trig_s_q, trig_d_q;
  logic [1:0] fill_q;
  logic       arm_q;
  logic       w_rise, w_fall;

  // FSM and datapath
  state_e           state_q, state_d;
  logic [CYC_W-1:0] cyc_cnt_q, cyc_cnt_d;
  logic [15:0]      us_cnt_q, us_cnt_d;
  logic [15:0]      echo_len_q, echo_len_d;
  logic [15:0]      trig_count_q, trig_count_d;
  logic             short_q, short_d;
  logic             echo_q;
  logic             w_tick, w_restart, w_long_enough;
  logic [15:0]      w_len_base, w_len_final;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sync1_q  <= 1'b0;
      trig_s_q <= 1'b0;
      trig_d_q <= 1'b0;
      fill_q   <= 2'b00;
      arm_q    <= 1'b0;
    end else begin
      sync1_q  <= i_trigger;
      trig_s_q <= sync1_q;
      trig_d_q <= trig_s_q;
      fill_q   <= {fill_q[0], 1'b1};
      // Arm only after a genuine low has travelled through the synchronizer,
      // so a line already high at reset release cannot look like a rise.
      if (fill_q[1] && !trig_s_q) begin
        arm_q <= 1'b1;
      end
    end
  end

  assign w_rise = trig_s_q & ~trig_d_q & arm_q;
  assign w_fall = ~trig_s_q & trig_d_q;

  // Restart the prescaler on every state change so each phase starts on a
  // whole microsecond boundary.
  assign w_restart = (state_d != state_q);

  us_tick_gen #(
    .CLK_MHZ (CLK_MHZ)
  ) u_tick (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_restart (w_restart),
    .o_tick    (w_tick)
  );

  assign w_long_enough = (cyc_cnt_q >= C_MIN_CYC);
  assign w_len_base    = ((i_echo_us == 16'd0) || (i_echo_us > C_TIMEOUT)) ? C_TIMEOUT
                                                                           : i_echo_us;

`ifdef HCSR04_RESP_JITTER_EN
  logic [15:0] lfsr_q;
  logic [16:0] w_len_sum;
  logic        w_accept;

  assign w_accept = (state_q == TRIG_HI) && w_fall && w_long_enough;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      lfsr_q <= LFSR_SEED;
    end else if (w_accept) begin
      lfsr_q <= {lfsr_q[14:0], ^(lfsr_q & LFSR_TAPS)};
    end
  end

  // Jitter uses the LFSR value current at the latch, before it steps.
  assign w_len_sum   = {1'b0, w_len_base} + {14'd0, lfsr_q[2:0]};
  assign w_len_final = (w_len_sum > {1'b0, C_TIMEOUT}) ? C_TIMEOUT : w_len_sum[15:0];
`else
  assign w_len_final = w_len_base;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q      <= IDLE;
      cyc_cnt_q    <= '0;
      us_cnt_q     <= '0;
      echo_len_q   <= '0;
      trig_count_q <= '0;
      short_q      <= 1'b0;
      echo_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cyc_cnt_q    <= cyc_cnt_d;
      us_cnt_q     <= us_cnt_d;
      echo_len_q   <= echo_len_d;
      trig_count_q <= trig_count_d;
      short_q      <= short_d;
      // One flop behind the state so the echo aligns with the pin latency.
      echo_q       <= (state_q == ECHO);
    end
  end

  always_comb begin
    state_d      = state_q;
    cyc_cnt_d    = cyc_cnt_q;
    us_cnt_d     = us_cnt_q;
    echo_len_d   = echo_len_q;
    trig_count_d = trig_count_q;
    short_d      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (w_rise && i_enable) begin
          state_d   = TRIG_HI;
          cyc_cnt_d = '0;
        end
      end

      TRIG_HI: begin
        if (w_fall) begin
          if (w_long_enough) begin
            echo_len_d   = w_len_final;
            trig_count_d = trig_count_q + 16'd1;
            us_cnt_d     = '0;
            state_d      = BURST;
          end else begin
            short_d = 1'b1;
            state_d = IDLE;
          end
        end else if (trig_s_q && (cyc_cnt_q != C_MIN_CYC)) begin
          cyc_cnt_d = cyc_cnt_q + CYC_W'(1);
        end
      end

      BURST: begin
        if (w_tick) begin
          if (us_cnt_q == C_BURST_LST) begin
            us_cnt_d = '0;
            state_d  = ECHO;
          end else begin
            us_cnt_d = us_cnt_q + 16'd1;
          end
        end
      end

      ECHO: begin
        if (w_tick) begin
          if (us_cnt_q == (echo_len_q - 16'd1)) begin
            us_cnt_d = '0;
            state_d  = HOLDOFF;
          end else begin
            us_cnt_d = us_cnt_q + 16'd1;
          end
        end
      end

      HOLDOFF: begin
        if (w_tick) begin
          if (us_cnt_q == C_HOLD_LST) begin
            us_cnt_d = '0;
            state_d  = IDLE;
          end else begin
            us_cnt_d = us_cnt_q + 16'd1;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign o_echo       = echo_q;
  assign o_busy       = (state_q != IDLE);
  assign o_short_trig = short_q;
  assign o_trig_count = trig_count_q;

endmodule
`default_nettype wire

// File: tb/tb_hcsr04_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_hcsr04_responder                                          |
// | Description : Scoreboard bench for hcsr04_responder with scaled-down       |
// |               timing. The driver predicts each response from the protocol  |
// |               rules and queues it; a monitor pops and compares whenever    |
// |               the DUT shows an echo pulse or a short-trigger pulse.        |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_hcsr04_responder;

  localparam int M   = 4;    // clocks per us
  localparam int MIN = 10;
  localparam int B   = 5;
  localparam int TO  = 120;
  localparam int H   = 20;
  localparam int MIN_CYC = MIN * M;

  logic        clk = 1'b0;
  logic        i_rst;
  logic        i_enable;
  logic [15:0] i_echo_us;
  logic        i_trigger;
  logic        o_echo;
  logic        o_busy;
  logic        o_short_trig;
  logic [15:0] o_trig_count;

  hcsr04_responder #(
    .CLK_MHZ     (M),
    .TRIG_MIN_US (MIN),
    .BURST_US    (B),
    .TIMEOUT_US  (TO),
    .HOLDOFF_US  (H)
  ) dut (
    .i_clk        (clk),
    .i_rst        (i_rst),
    .i_enable     (i_enable),
    .i_echo_us    (i_echo_us),
    .i_trigger    (i_trigger),
    .o_echo       (o_echo),
    .o_busy       (o_busy),
    .o_short_trig (o_short_trig),
    .o_trig_count (o_trig_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit          is_short;
    int          t_exp;
    int          width;
    logic [15:0] count;
  } exp_t;

  exp_t        sb[$];
  int          total = 0;
  int          bad   = 0;
  logic [15:0] count_m = 16'd0;
  logic [15:0] lfsr_m  = 16'hACE1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- monitor ----------------
  bit   echo_act = 1'b0;
  int   rise_t   = 0;
  exp_t mon_e;

  initial begin
    forever begin
      @(negedge clk);
      if (i_rst) begin
        echo_act = 1'b0;
      end else begin
        if (o_short_trig) begin
          if (sb.size() == 0) begin
            chk("short_unexpected", 1, 0);
          end else begin
            mon_e = sb.pop_front();
            chk("short_kind", mon_e.is_short, 1);
            chk("short_time", cyc, mon_e.t_exp);
            chk("short_busy", o_busy, 0);
            chk("short_count", o_trig_count, mon_e.count);
          end
        end
        if (o_echo && !echo_act) begin
          echo_act = 1'b1;
          rise_t   = cyc;
        end else if (!o_echo && echo_act) begin
          echo_act = 1'b0;
          if (sb.size() == 0) begin
            chk("echo_unexpected", 1, 0);
          end else begin
            mon_e = sb.pop_front();
            chk("echo_kind", mon_e.is_short, 0);
            chk("echo_rise_time", rise_t, mon_e.t_exp);
            chk("echo_width", cyc - rise_t, mon_e.width);
            chk("echo_count", o_trig_count, mon_e.count);
          end
        end
      end
    end
  end

  // ---------------- driver helpers ----------------
  task automatic wait_until(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  // Called at a negedge; returns the edge number that first samples the low.
  task automatic pulse(input int w, output int s);
    i_trigger = 1'b1;
    repeat (w) @(negedge clk);
    i_trigger = 1'b0;
    s = cyc + 1;
  endtask

  // inj: 0 none, 1 extra trigger during ECHO, 2 extra trigger during HOLDOFF
  task automatic do_txn(input bit en, input logic [15:0] e, input int w, input int inj);
    int s, s2, len, jit, idle;
    @(negedge clk);
    i_enable  = en;
    i_echo_us = e;
    pulse(w, s);
    if (!en) begin
      wait_until(s + 4);
      chk("disabled_busy", o_busy, 0);
      i_enable = 1'b1;
      return;
    end
    // The trigger high time is w cycles; acceptance needs at least MIN_CYC
    // counted cycles after the rising edge is seen.
    if (w - 1 < MIN_CYC) begin
      sb.push_back('{1'b1, s + 2, 0, count_m});
      wait_until(s + 6);
      return;
    end
    len = ((e == 16'd0) || (int'(e) > TO)) ? TO : int'(e);
    jit = 0;
`ifdef HCSR04_RESP_JITTER_EN
    jit    = int'(lfsr_m[2:0]);
    lfsr_m = {lfsr_m[14:0], lfsr_m[15] ^ lfsr_m[13] ^ lfsr_m[12] ^ lfsr_m[10]};
`endif
    len = len + jit;
    if (len > TO) len = TO;
    count_m = count_m + 16'd1;
    sb.push_back('{1'b0, s + 3 + B * M, len * M, count_m});

    wait_until(s + 3);
    if ($urandom_range(1, 0) == 1) i_echo_us = 16'($urandom);
    if ($urandom_range(3, 0) == 0) i_enable = 1'b0;
    if (inj == 1) begin
      wait_until(s + 3 + B * M + 2);
      pulse(MIN_CYC + 4, s2);
    end else if (inj == 2) begin
      wait_until(s + 3 + (B + len) * M + 8);
      pulse(MIN_CYC + 4, s2);
    end
    idle = s + 2 + (B + len + H) * M;
    wait_until(idle - 1);
    chk("busy_before_idle", o_busy, 1);
    wait_until(idle);
    chk("idle_after_holdoff", o_busy, 0);
    i_enable = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int s;
    int w;
    logic [15:0] e;
    i_rst     = 1'b1;
    i_enable  = 1'b0;
    i_echo_us = 16'd0;
    i_trigger = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_echo", o_echo, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_short", o_short_trig, 0);
    chk("rst_count", o_trig_count, 0);
    i_rst    = 1'b0;
    i_enable = 1'b1;
    repeat (5) @(negedge clk);

    do_txn(1'b1, 16'd58, 12 * M, 0);      // nominal accepted trigger
    do_txn(1'b1, 16'd58, 9 * M, 0);       // too short
    do_txn(1'b1, 16'd0, 12 * M, 0);       // zero -> timeout width
    do_txn(1'b1, 16'd50000, 12 * M, 0);   // out of range -> timeout width
    do_txn(1'b1, 16'd40, 12 * M, 1);      // ignored trigger during ECHO
    do_txn(1'b1, 16'd40, 12 * M, 2);      // ignored trigger during HOLDOFF
    do_txn(1'b0, 16'd40, 12 * M, 0);      // disabled
    for (int k = 0; k < 4; k++) do_txn(1'b1, 16'd100, 12 * M, 0);

    for (int k = 0; k < 24; k++) begin
      case ($urandom_range(9, 0))
        0:       e = 16'd0;
        1:       e = 16'd50000;
        default: e = 16'($urandom_range(TO + 20, 1));
      endcase
      if ($urandom_range(3, 0) == 0) w = $urandom_range(MIN_CYC - 4, 2);
      else                           w = $urandom_range(MIN_CYC + 40, MIN_CYC + 4);
      do_txn($urandom_range(7, 0) != 0, e, w, $urandom_range(2, 0));
    end

    // Reset in the middle of ECHO aborts at once.
    @(negedge clk);
    i_echo_us = 16'd60;
    pulse(12 * M, s);
    wait_until(s + 3 + B * M + 100);
    chk("mid_echo_high", o_echo, 1);
    sb.delete();
    i_rst = 1'b1;
    @(negedge clk);
    chk("abort_echo", o_echo, 0);
    chk("abort_busy", o_busy, 0);
    chk("abort_count", o_trig_count, 0);
    count_m   = 16'd0;
    lfsr_m    = 16'hACE1;
    i_trigger = 1'b1;                     // held high across release
    @(negedge clk);
    i_rst = 1'b0;
    repeat (30) @(negedge clk);
    chk("held_high_busy", o_busy, 0);
    chk("held_high_count", o_trig_count, 0);
    i_trigger = 1'b0;
    repeat (6) @(negedge clk);
    do_txn(1'b1, 16'd30, 12 * M, 0);

    repeat (20) @(negedge clk);
    chk("scoreboard_empty", sb.size(), 0);
    chk("final_count", o_trig_count, count_m);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/hcsr04_responder.md
Name: hcsr04_responder

Overview:
- Sensor-side end of the HC-SR04 trigger/echo protocol: accepts a trigger pulse and answers with an echo pulse whose width encodes a programmed distance.
- Stands in for a physical ultrasonic module on a PMOD header. Used for hardware-in-loop and for simulation of the ultrasonic peripheral without the real sensor.
- The programmed echo width is supplied by a Wishbone register block or a testbench.

Parameters:
- CLK_MHZ, 64, i_clk frequency in MHz; i_clk cycles per microsecond.
- TRIG_MIN_US, 10, minimum trigger high time in µs for the trigger to be accepted.
- BURST_US, 200, delay in µs from trigger fall to echo rise (emulated 8-cycle 40 kHz burst).
- TIMEOUT_US, 38000, echo width in µs for no-object/out-of-range; also the saturation limit.
- HOLDOFF_US, 10000, dead time in µs after echo fall during which triggers are ignored.

Ports:
- i_clk  in  1  single clock; every register is in this domain.
- i_rst  in  1  synchronous, active-high reset.
- i_enable  in  1  allows new triggers to be accepted; checked only in IDLE.
- i_echo_us  in  16  programmed echo width in µs; latched when a trigger is accepted.
- i_trigger  in  1  asynchronous trigger pin from the controller.
- o_echo  out  1  echo pin to the controller.
- o_busy  out  1  high whenever the state is not IDLE.
- o_short_trig  out  1  one-cycle pulse when a trigger is rejected for being too short.
- o_trig_count  out  16  count of accepted triggers; wraps at 65535 -> 0.

Behaviour:
- Reset (i_rst high at a clock edge):
  - o_echo=0, o_busy=0, o_short_trig=0, o_trig_count=0; state=IDLE; synchronizer and all counters cleared.
  - Reset mid-operation aborts immediately; o_echo is low from the next cycle.
- Synchronizer: i_trigger passes through 2 flops to give trig_s; trig_d is a one-cycle delay of trig_s.
  - rise = trig_s & !trig_d; fall = !trig_s & trig_d.
- µs tick: prescaler counts 0..CLK_MHZ-1 and pulses a tick at CLK_MHZ-1. It restarts from 0 on every state entry, so latencies are exact. All µs counters are 16 bits and advance only on a tick.
- IDLE:
  - rise & i_enable -> TRIG_HI, and the cycle counter is cleared.
  - A trigger already high when leaving reset or enable never starts a cycle; a rising edge is required.
- TRIG_HI:
  - Count i_clk cycles while trig_s is high; the counter saturates at TRIG_MIN_US*CLK_MHZ.
  - On fall with count >= TRIG_MIN_US*CLK_MHZ:
    - latch echo_len = (i_echo_us==0 || i_echo_us>TIMEOUT_US) ? TIMEOUT_US : i_echo_us;
    - increment o_trig_count;
    - go to BURST.
  - On fall with count below the minimum: pulse o_short_trig for 1 cycle, go to IDLE.
- BURST: o_echo low for exactly BURST_US µs, then go to ECHO.
- ECHO: o_echo high for exactly echo_len*CLK_MHZ cycles, then go to HOLDOFF.
- HOLDOFF: o_echo low for HOLDOFF_US µs, then go to IDLE.
- Latency: o_echo rises exactly 3 + BURST_US*CLK_MHZ cycles after the first i_clk edge that samples i_trigger low.
- Triggers arriving in BURST, ECHO or HOLDOFF are ignored: no count increment, no o_short_trig.
- i_enable going low mid-cycle does not abort; the current cycle completes.
- i_echo_us changes after the latch do not affect the echo in progress.
- o_echo and o_short_trig are driven directly from flops, with no combinational path from inputs.

Optional Feature:
- Macro HCSR04_RESP_JITTER_EN.
- When defined:
  - A 16-bit Fibonacci LFSR (taps 16,14,13,11; seed 16'hACE1 at reset) steps once per accepted trigger.
  - Its low 3 bits (0..7 µs) are added to echo_len at latch; the sum is saturated to TIMEOUT_US.
- When undefined: no LFSR exists, and the echo width is exactly echo_len.

Decomposition:
- Package hcsr04_pkg holds:
  - state enum: IDLE, TRIG_HI, BURST, ECHO, HOLDOFF;
  - default constants for TIMEOUT_US and TRIG_MIN_US;
  - the LFSR seed and tap constants.
- One sub-module, us_tick_gen (parameter CLK_MHZ; inputs i_clk, i_rst, i_restart; output o_tick).

Test Plan:
- Defaults, i_echo_us=580, 12 µs trigger (768 cycles) -> o_echo rises 3+12800 cycles after the sampled fall, high exactly 37120 cycles; o_trig_count=1.
- 9 µs trigger (576 cycles) -> o_short_trig one pulse, o_echo stays 0, o_trig_count unchanged, o_busy back to 0 within 1 cycle.
- i_echo_us=0 and, separately, i_echo_us=50000 -> echo width 38000 µs (2,432,000 cycles) in both cases.
- Second 12 µs trigger during ECHO, and another 5000 µs into HOLDOFF -> both ignored, count unchanged; a trigger after HOLDOFF ends -> accepted.
- i_rst asserted mid-ECHO -> next cycle o_echo=0, o_busy=0, o_trig_count=0; trigger held high across reset release -> no cycle starts until low then high.
- With HCSR04_RESP_JITTER_EN, 4 triggers at i_echo_us=100 -> widths match the reference LFSR model (100..107 µs); without the macro -> all exactly 100 µs.
